// File: rtl/ps2_event_decoder.sv
// PS/2 set-2 scancode decoder: prefix tracking, modifier/Caps Lock state,
// optional typematic-repeat suppression, and a show-ahead event FIFO.
module ps2_event_decoder #(
   parameter int FIFO_DEPTH      = 8,
   parameter bit REPORT_BREAKS   = 1'b0,
   parameter bit SUPPRESS_REPEAT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scancode_valid,
   input  logic [7:0]  scancode,
   output logic        event_valid,
   input  logic        event_ready,
   output logic [15:0] event_data,
   output logic [6:0]  mod_state,
   output logic [7:0]  overflow_count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK,
      S_SKIP
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  skip_cnt_q, skip_cnt_d;

   logic        done;
   logic        done_brk;
   logic        done_ext;
   logic        ignored;

   // {r_alt, l_alt, r_ctrl, l_ctrl, r_shift, l_shift}
   logic [5:0]  mods_q, mods_d;
   logic        caps_q, caps_d;
   logic        caps_down_q, caps_down_d;
   logic        held_valid_q, held_valid_d;
   logic        held_ext_q, held_ext_d;
   logic [7:0]  held_code_q, held_code_d;
   logic        held_match;
   logic        is_mod;
   logic        push_req;
   logic [15:0] event_word;

   logic [15:0] mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        fifo_empty, fifo_full;
   logic        push, pop, drop;
   logic [7:0]  ovf_q;

   assign ignored = scancode inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      skip_cnt_d = skip_cnt_q;
      done       = 1'b0;
      done_brk   = 1'b0;
      done_ext   = 1'b0;
      if (scancode_valid) begin
         if (state_q == S_SKIP) begin
            if (skip_cnt_q == 3'd6) begin
               state_d    = S_IDLE;
               skip_cnt_d = 3'd0;
            end else begin
               skip_cnt_d = skip_cnt_q + 3'd1;
            end
         end else if (!ignored) begin
            case (state_q)
               S_IDLE: begin
                  if (scancode == 8'hE0)      state_d = S_EXT;
                  else if (scancode == 8'hF0) state_d = S_BRK;
                  else if (scancode == 8'hE1) begin
                     state_d    = S_SKIP;
                     skip_cnt_d = 3'd0;
                  end else begin
                     done = 1'b1;
                  end
               end
               S_EXT: begin
                  if (scancode == 8'hF0)      state_d = S_EXT_BRK;
                  else if (scancode != 8'hE0) begin
                     done     = 1'b1;
                     done_ext = 1'b1;
                     state_d  = S_IDLE;
                  end
               end
               S_BRK: begin
                  done     = 1'b1;
                  done_brk = 1'b1;
                  state_d  = S_IDLE;
               end
               S_EXT_BRK: begin
                  done     = 1'b1;
                  done_brk = 1'b1;
                  done_ext = 1'b1;
                  state_d  = S_IDLE;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   assign held_match = held_valid_q && (held_ext_q == done_ext) && (held_code_q == scancode);

   // Modifier fields come from state before this byte's update.
   assign event_word = {done_brk, done_ext, caps_q, |mods_q[5:4], |mods_q[3:2],
                        |mods_q[1:0], 2'b00, scancode};

   always_comb begin
      mods_d       = mods_q;
      caps_d       = caps_q;
      caps_down_d  = caps_down_q;
      held_valid_d = held_valid_q;
      held_ext_d   = held_ext_q;
      held_code_d  = held_code_q;
      is_mod       = 1'b0;
      push_req     = 1'b0;
      if (done) begin
         is_mod = 1'b1;
         case ({done_ext, scancode})
            {1'b0, 8'h12}: mods_d[0] = !done_brk;
            {1'b0, 8'h59}: mods_d[1] = !done_brk;
            {1'b0, 8'h14}: mods_d[2] = !done_brk;
            {1'b1, 8'h14}: mods_d[3] = !done_brk;
            {1'b0, 8'h11}: mods_d[4] = !done_brk;
            {1'b1, 8'h11}: mods_d[5] = !done_brk;
            {1'b1, 8'h12}, {1'b1, 8'h59}: ;
            default: is_mod = 1'b0;
         endcase
         if (!is_mod) begin
            if (!done_brk) begin
               if (!done_ext && scancode == 8'h58) begin
                  if (!caps_down_q) caps_d = !caps_q;
                  caps_down_d = 1'b1;
               end
               if (!(SUPPRESS_REPEAT && held_match)) begin
                  push_req     = 1'b1;
                  held_valid_d = 1'b1;
                  held_ext_d   = done_ext;
                  held_code_d  = scancode;
               end
            end else begin
               if (!done_ext && scancode == 8'h58) caps_down_d = 1'b0;
               if (held_match) held_valid_d = 1'b0;
               push_req = REPORT_BREAKS;
            end
         end
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = !fifo_empty && event_ready;
   assign push       = push_req && (!fifo_full || pop);
   assign drop       = push_req && fifo_full && !pop;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         skip_cnt_q   <= 3'd0;
         mods_q       <= 6'd0;
         caps_q       <= 1'b0;
         caps_down_q  <= 1'b0;
         held_valid_q <= 1'b0;
         held_ext_q   <= 1'b0;
         held_code_q  <= 8'h00;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ovf_q        <= 8'h00;
      end else begin
         state_q      <= state_d;
         skip_cnt_q   <= skip_cnt_d;
         mods_q       <= mods_d;
         caps_q       <= caps_d;
         caps_down_q  <= caps_down_d;
         held_valid_q <= held_valid_d;
         held_ext_q   <= held_ext_d;
         held_code_q  <= held_code_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
      end
   end

   // NOTE: storage is not reset; the pointers define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= event_word;
   end

   assign event_valid    = !fifo_empty;
   assign event_data     = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q[AW-1:0]];
   assign mod_state      = {caps_q, mods_q};
   assign overflow_count = ovf_q;

endmodule
